multicycle_sequencer: RTL and testbench

//  Sequencing FSM for the multi-cycle RV32I subset core. It steps one instruction at a time

---
 rtl/multicycle_sequencer_pkg.sv | 44 ++++
 rtl/multicycle_sequencer_if.sv | 10 +
 rtl/multicycle_sequencer_wait_timer.sv | 31 +++
 rtl/multicycle_sequencer.sv | 141 ++++++++++++++
 tb/tb_multicycle_sequencer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// Shared types for the multi-cycle RV32I sequencer: FSM states, opcode constants,
// and the trap-cause / destination-select encodings also seen by the datapath muxes.
package multicycle_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_ALU,
        ST_EXEC_ADDR,
        ST_MEM,
        ST_WB_ALU,
        ST_WB_MEM,
        ST_TRAP
    } seq_state_t;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_ILLEGAL  = 2'b01,
        CAUSE_FETCH_TO = 2'b10,
        CAUSE_DATA_TO  = 2'b11
    } trap_cause_t;

    typedef enum logic [1:0] {
        DEST_ALU = 2'b00,
        DEST_MEM = 2'b01,
        DEST_IMM = 2'b10
    } dest_sel_t;

    // Where DECODE goes for a given opcode; anything unsupported lands in TRAP.
    function automatic seq_state_t decode_next(input logic [6:0] op);
        case (op)
            OP_RTYPE, OP_ITYPE, OP_LUI: return ST_EXEC_ALU;
            OP_LOAD, OP_STORE:          return ST_EXEC_ADDR;
            default:                    return ST_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Shared memory-port handshake between the sequencer (master) and the memory (slave).
interface multicycle_sequencer_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output addr_sel, input mem_ready);
    modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ready);
endinterface

// File: rtl/multicycle_sequencer_wait_timer.sv
// Counts consecutive unacknowledged memory-request cycles; flags expiry when the
// count sits at WAIT_LIMIT and the request is still not acknowledged.
module multicycle_sequencer_wait_timer #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic done,
    input  logic clear,
    output logic expired
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || done || !active) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    // An acknowledge in the limit cycle wins over expiry.
    assign expired = active && !done && (count == LIMIT);

endmodule

// File: rtl/multicycle_sequencer.sv
// Per-phase control FSM for the multi-cycle RV32I subset core: one instruction at a time
// through FETCH/DECODE/EXEC/MEM/WB, with a bounded memory wait and a sticky TRAP state.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [6:0]                    opcode,
    multicycle_sequencer_if.master        bus,
    output logic                          ir_write,
    output logic                          pc_write,
    output logic                          alu_en,
    output logic                          reg_write,
    output logic [1:0]                    dest_sel,
    output logic                          retire,
    output logic                          trap,
    output logic [1:0]                    trap_cause
);
    seq_state_t  state, state_next;
    trap_cause_t cause_q, cause_next;
    dest_sel_t   dest_c;
    logic        cause_set;
    logic        mem_req_c, mem_we_c, addr_sel_c;
    logic        expired;

    multicycle_sequencer_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT),
        .CNT_W      (CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .active  (mem_req_c),
        .done    (bus.mem_ready),
        .clear   (state_next != state),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_FETCH;
            cause_q <= CAUSE_NONE;
        end else begin
            state <= state_next;
            if (cause_set) begin
                cause_q <= cause_next;
            end
        end
    end

    always_comb begin
        state_next = state;
        cause_set  = 1'b0;
        cause_next = CAUSE_NONE;
        mem_req_c  = 1'b0;
        mem_we_c   = 1'b0;
        addr_sel_c = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        alu_en     = 1'b0;
        reg_write  = 1'b0;
        dest_c     = DEST_ALU;
        retire     = 1'b0;

        case (state)
            ST_FETCH: begin
                mem_req_c = 1'b1;
                // Held in reset, the Mealy writes must stay quiet even if memory answers.
                if (bus.mem_ready && rst_n) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = ST_DECODE;
                end else if (expired) begin
                    state_next = ST_TRAP;
                    cause_set  = 1'b1;
                    cause_next = CAUSE_FETCH_TO;
                end
            end
            ST_DECODE: begin
                state_next = decode_next(opcode);
                if (state_next == ST_TRAP) begin
                    cause_set  = 1'b1;
                    cause_next = CAUSE_ILLEGAL;
                end
            end
            ST_EXEC_ALU: begin
                alu_en     = 1'b1;
                state_next = ST_WB_ALU;
            end
            ST_EXEC_ADDR: begin
                alu_en     = 1'b1;
                state_next = ST_MEM;
            end
            ST_MEM: begin
                mem_req_c  = 1'b1;
                addr_sel_c = 1'b1;
                mem_we_c   = (opcode == OP_STORE);
                if (bus.mem_ready) begin
                    if (opcode == OP_STORE) begin
                        retire     = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_WB_MEM;
                    end
                end else if (expired) begin
                    state_next = ST_TRAP;
                    cause_set  = 1'b1;
                    cause_next = CAUSE_DATA_TO;
                end
            end
            ST_WB_ALU: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                dest_c     = (opcode == OP_LUI) ? DEST_IMM : DEST_ALU;
                state_next = ST_FETCH;
            end
            ST_WB_MEM: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                dest_c     = DEST_MEM;
                state_next = ST_FETCH;
            end
            ST_TRAP: begin
                state_next = ST_TRAP;
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    assign bus.mem_req  = mem_req_c;
    assign bus.mem_we   = mem_we_c;
    assign bus.addr_sel = addr_sel_c;
    assign dest_sel     = dest_c;
    assign trap         = (state == ST_TRAP);
    assign trap_cause   = cause_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: each driven cycle queues its expected output
// vector; a negedge monitor pops and compares against what the DUT presents.
module tb_multicycle_sequencer;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic       ir_write, pc_write, alu_en, reg_write, retire, trap;
    logic [1:0] dest_sel, trap_cause;

    multicycle_sequencer_if bus();

    multicycle_sequencer #(.WAIT_LIMIT(15), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .bus        (bus),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .alu_en     (alu_en),
        .reg_write  (reg_write),
        .dest_sel   (dest_sel),
        .retire     (retire),
        .trap       (trap),
        .trap_cause (trap_cause)
    );

    typedef struct {
        string      nm;
        logic [12:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    localparam logic [6:0] R_OP  = 7'b0110011;
    localparam logic [6:0] I_OP  = 7'b0010011;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] LD    = 7'b0000011;
    localparam logic [6:0] ST    = 7'b0100011;
    localparam logic [6:0] BAD   = 7'b1111111;

    // Vector layout: {mem_req, mem_we, addr_sel, ir_write, pc_write, alu_en, reg_write,
    //                 dest_sel[1:0], retire, trap, trap_cause[1:0]}
    function automatic logic [12:0] ev(input bit mreq, input bit we, input bit asel,
                                       input bit irw, input bit pcw, input bit alu,
                                       input bit rw, input bit [1:0] ds, input bit ret,
                                       input bit trp, input bit [1:0] c);
        return {mreq, we, asel, irw, pcw, alu, rw, ds, ret, trp, c};
    endfunction

    logic [12:0] V_FW, V_FD, V_DEC, V_EX, V_WB, V_WBLUI, V_MW, V_SW, V_SD, V_WBM;
    logic [12:0] V_T01, V_T10, V_T11;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1);
    end

    always @(negedge clk) begin
        exp_t e;
        logic [12:0] got;
        if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            got = {bus.mem_req, bus.mem_we, bus.addr_sel, ir_write, pc_write, alu_en,
                   reg_write, dest_sel, retire, trap, trap_cause};
            n_checks++;
            if (got === e.exp) n_pass++;
            else $display("FAIL %s: got %b expected %b", e.nm, got, e.exp);
        end
    end

    task automatic step(input string nm, input bit rdy, input logic [6:0] op,
                        input logic [12:0] exp);
        bus.mem_ready = rdy;
        opcode        = op;
        sb_q.push_back('{nm, exp});
        @(posedge clk);
        #1;
    endtask

    // Same as step, but rst_n falls partway through the cycle, before the monitor samples.
    task automatic step_rst(input string nm, input bit rdy, input logic [6:0] op,
                            input logic [12:0] exp);
        bus.mem_ready = rdy;
        opcode        = op;
        sb_q.push_back('{nm, exp});
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse(input string nm);
        rst_n = 1'b0;
        step(nm, 1'b1, R_OP, V_FW);
        rst_n = 1'b1;
    endtask

    initial begin
        V_FW    = ev(1,0,0,0,0,0,0,2'b00,0,0,2'b00);
        V_FD    = ev(1,0,0,1,1,0,0,2'b00,0,0,2'b00);
        V_DEC   = ev(0,0,0,0,0,0,0,2'b00,0,0,2'b00);
        V_EX    = ev(0,0,0,0,0,1,0,2'b00,0,0,2'b00);
        V_WB    = ev(0,0,0,0,0,0,1,2'b00,1,0,2'b00);
        V_WBLUI = ev(0,0,0,0,0,0,1,2'b10,1,0,2'b00);
        V_MW    = ev(1,0,1,0,0,0,0,2'b00,0,0,2'b00);
        V_SW    = ev(1,1,1,0,0,0,0,2'b00,0,0,2'b00);
        V_SD    = ev(1,1,1,0,0,0,0,2'b00,1,0,2'b00);
        V_WBM   = ev(0,0,0,0,0,0,1,2'b01,1,0,2'b00);
        V_T01   = ev(0,0,0,0,0,0,0,2'b00,0,1,2'b01);
        V_T10   = ev(0,0,0,0,0,0,0,2'b00,0,1,2'b10);
        V_T11   = ev(0,0,0,0,0,0,0,2'b00,0,1,2'b11);

        rst_n         = 1'b0;
        opcode        = R_OP;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        step("rst_idle",  1'b0, R_OP, V_FW);
        step("rst_ready", 1'b1, R_OP, V_FW);
        rst_n = 1'b1;

        // R-type with zero-wait memory: 4 cycles FETCH to FETCH.
        step("r_fetch",  1'b1, R_OP, V_FD);
        step("r_decode", 1'b1, R_OP, V_DEC);
        step("r_exec",   1'b1, R_OP, V_EX);
        step("r_wb",     1'b1, R_OP, V_WB);

        step("i_fetch",  1'b1, I_OP, V_FD);
        step("i_decode", 1'b1, I_OP, V_DEC);
        step("i_exec",   1'b1, I_OP, V_EX);
        step("i_wb",     1'b1, I_OP, V_WB);

        step("lui_fetch",  1'b1, LUI, V_FD);
        step("lui_decode", 1'b1, LUI, V_DEC);
        step("lui_exec",   1'b1, LUI, V_EX);
        step("lui_wb",     1'b1, LUI, V_WBLUI);

        // Load with three data stall cycles.
        step("ld_fetch",  1'b1, LD, V_FD);
        step("ld_decode", 1'b1, LD, V_DEC);
        step("ld_exec",   1'b1, LD, V_EX);
        for (int i = 0; i < 3; i++) step($sformatf("ld_mem_wait%0d", i), 1'b0, LD, V_MW);
        step("ld_mem_done", 1'b1, LD, V_MW);
        step("ld_wb",       1'b1, LD, V_WBM);

        // Store with one data stall cycle.
        step("st_fetch",     1'b1, ST, V_FD);
        step("st_decode",    1'b1, ST, V_DEC);
        step("st_exec",      1'b1, ST, V_EX);
        step("st_mem_wait",  1'b0, ST, V_SW);
        step("st_mem_done",  1'b1, ST, V_SD);

        // Fetch acknowledged in the very cycle the wait count reaches the limit.
        for (int i = 0; i < 15; i++) step($sformatf("fb_wait%0d", i), 1'b0, R_OP, V_FW);
        step("fb_edge_ack", 1'b1, R_OP, V_FD);
        step("fb_decode",   1'b1, R_OP, V_DEC);
        step("fb_exec",     1'b1, R_OP, V_EX);
        step("fb_wb",       1'b1, R_OP, V_WB);

        // Illegal opcode: sticky trap with cause 01, memory ignored.
        step("ill_fetch",  1'b1, BAD, V_FD);
        step("ill_decode", 1'b1, BAD, V_DEC);
        for (int i = 0; i < 4; i++) step($sformatf("ill_trap%0d", i), 1'b1, BAD, V_T01);
        reset_pulse("ill_reset");

        // Fetch timeout: 16 FETCH cycles, then trap with cause 10.
        for (int i = 0; i < 16; i++) step($sformatf("fto_wait%0d", i), 1'b0, R_OP, V_FW);
        for (int i = 0; i < 3; i++)  step($sformatf("fto_trap%0d", i), 1'b1, R_OP, V_T10);
        reset_pulse("fto_reset");

        // Data timeout on a load: 16 MEM cycles, then trap with cause 11.
        step("dto_fetch",  1'b1, LD, V_FD);
        step("dto_decode", 1'b1, LD, V_DEC);
        step("dto_exec",   1'b1, LD, V_EX);
        for (int i = 0; i < 16; i++) step($sformatf("dto_wait%0d", i), 1'b0, LD, V_MW);
        for (int i = 0; i < 2; i++)  step($sformatf("dto_trap%0d", i), 1'b1, LD, V_T11);
        reset_pulse("dto_reset");

        // Asynchronous reset in the middle of a load's data wait.
        step("ar_fetch",  1'b1, LD, V_FD);
        step("ar_decode", 1'b1, LD, V_DEC);
        step("ar_exec",   1'b1, LD, V_EX);
        step("ar_wait0",  1'b0, LD, V_MW);
        step_rst("ar_drop_rst", 1'b0, LD, V_FW);
        step("ar_in_rst_ready", 1'b1, LD, V_FW);
        rst_n = 1'b1;
        step("ar_refetch", 1'b1, R_OP, V_FD);
        step("ar_decode2", 1'b1, R_OP, V_DEC);

        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
